// File: rtl/pll_lock_pkg.sv
// pll_lock_pkg: shared types and helpers for the PLL lock manager.
//   state_t  : lock sequencer states (3-bit encoding)
//   sat_inc  : saturating increment for counters up to 32 bits wide
//   max3     : largest of three integers, used to size the shared timer
package pll_lock_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // Increments v, holding at 2^w-1 instead of wrapping. Caller casts to its width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_manager_sync2.sv
// sync2: generic two-flop synchroniser for a single control bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   i_d   : asynchronous input
//   o_q   : synchronised output, two destination cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pll_lock_manager.sv
// pll_lock_manager: sequences PLL reset and lock acquisition on the reference
// clock, qualifies lock stability, then releases the core reset. Handles lock
// loss, lock timeouts with retry, and a terminal FAIL state left via relock_req.
//   clk           : 50 MHz reference clock
//   rst_n         : asynchronous active-low reset
//   pll_locked    : PLL locked, asynchronous (synchronised internally)
//   relock_req    : one-cycle request to restart the sequence
//   pll_rst       : PLL reset, active high
//   core_rst_n    : core reset, active low
//   lock_ok       : high in RUN
//   lock_fail     : high in FAIL
//   lock_loss_cnt : RUN lock-loss events, saturating
//   retry_cnt     : lock timeouts since last relock/reset/RUN entry, saturating
// Build option: define PLL_LOCK_STATS_EN to implement the two statistics
// counters; otherwise both ports read 0 and only the internal retry count exists.
// CNT_W is limited to 32 bits by the saturating-increment helper.
module pll_lock_manager #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             core_rst_n,
    output logic             lock_ok,
    output logic             lock_fail,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);
    import pll_lock_pkg::*;

    localparam int TMR_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RTRY_W  = $clog2(MAX_RETRIES + 1);

    state_t            r_state;
    state_t            w_nxt;
    logic [TMR_W-1:0]  r_tmr;
    logic [RTRY_W-1:0] r_rtry;
    logic              w_lk;
    logic              w_timeout;
    logic              w_enter_run;
    logic              r_pll_rst;
    logic              r_core_rst_n;
    logic              r_lock_ok;
    logic              r_lock_fail;

    sync2 u_lk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_lk)
    );

    // Timer counts cycles spent in the current state; the compare values are
    // N-1 so each state lasts exactly N cycles.
    always_comb begin
        w_nxt     = r_state;
        w_timeout = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_tmr == TMR_W'(PLL_RST_CYCLES - 1)) w_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lk) begin
                    w_nxt = STABLE;
                end else if (r_tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    // This timeout is the MAX_RETRIES-th one when the count is one short.
                    w_nxt = (r_rtry >= RTRY_W'(MAX_RETRIES - 1)) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!w_lk)                                   w_nxt = WAIT_LOCK;
                else if (r_tmr == TMR_W'(STABLE_CYCLES - 1)) w_nxt = RUN;
            end
            RUN: begin
                if (!w_lk) w_nxt = PLL_RST;
            end
            FAIL:    w_nxt = FAIL;
            default: w_nxt = PLL_RST;
        endcase
        // Relock overrides everything, including any timeout bookkeeping.
        if (relock_req) begin
            w_nxt     = PLL_RST;
            w_timeout = 1'b0;
        end
    end

    assign w_enter_run = (w_nxt == RUN) && (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PLL_RST;
            r_pll_rst    <= 1'b1;
            r_core_rst_n <= 1'b0;
            r_lock_ok    <= 1'b0;
            r_lock_fail  <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_pll_rst    <= (w_nxt == PLL_RST) || (w_nxt == FAIL);
            r_core_rst_n <= (w_nxt == RUN);
            r_lock_ok    <= (w_nxt == RUN);
            r_lock_fail  <= (w_nxt == FAIL);
        end
    end

    // Relock re-enters PLL_RST even from PLL_RST, so it also counts as an entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_tmr <= '0;
        else if (w_nxt != r_state || relock_req)   r_tmr <= '0;
        else if (r_tmr != TMR_W'(TMR_MAX))         r_tmr <= r_tmr + 1'b1;
    end

    // Internal retry count drives FAIL detection in every build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_rtry <= '0;
        else if (relock_req || w_enter_run) r_rtry <= '0;
        else if (w_timeout)                 r_rtry <= RTRY_W'(sat_inc(32'(r_rtry), RTRY_W));
    end

`ifdef PLL_LOCK_STATS_EN
    logic [CNT_W-1:0] r_loss_cnt;
    logic [CNT_W-1:0] r_retry_cnt;
    logic             w_loss;

    // A relock in the same cycle as a lock drop is not counted as a loss.
    assign w_loss = (r_state == RUN) && !w_lk && !relock_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_loss_cnt <= '0;
        else if (w_loss) r_loss_cnt <= CNT_W'(sat_inc(32'(r_loss_cnt), CNT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_retry_cnt <= '0;
        else if (relock_req || w_enter_run) r_retry_cnt <= '0;
        else if (w_timeout)                 r_retry_cnt <= CNT_W'(sat_inc(32'(r_retry_cnt), CNT_W));
    end

    assign lock_loss_cnt = r_loss_cnt;
    assign retry_cnt     = r_retry_cnt;
`else
    assign lock_loss_cnt = '0;
    assign retry_cnt     = '0;
`endif

    assign pll_rst    = r_pll_rst;
    assign core_rst_n = r_core_rst_n;
    assign lock_ok    = r_lock_ok;
    assign lock_fail  = r_lock_fail;

endmodule
